decoder_scan_n: RTL and testbench
=================================

# decoder_scan_n

Parametrised, registered one-of-N active-low decoder with an optional auto-scan sequencer. In direct mode it decodes `i_sel` like the team's 3-to-8 decoder, with the output registered. In scan mode it steps through indices 0..`i_last` at a programmable rate, which drives digit and row strobes for multiplexed LED and 7-segment displays. It sits between the display controller's register file and the strobe pins.

## Interface
Parameters:
- `SEL_W`, 3, select width; output width `OUT_N = 2**SEL_W` (derived, not overridable)
- `DIV_W`, 16, prescaler width

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_en`  in  1  output enable; 0 forces all outputs inactive
- `i_mode`  in  1  0 = direct, 1 = scan
- `i_sel`  in  SEL_W  direct-mode index
- `i_div`  in  DIV_W  scan step period minus 1, in clocks
- `i_last`  in  SEL_W  highest scan index (wrap point)
- `o_y`  out  OUT_N  active-low one-hot strobe; all ones = none active
- `o_idx`  out  SEL_W  index currently driven
- `o_tick`  out  1  one-cycle pulse when the scan index advances

## Operation
- Reset values: `o_y` = all ones, `o_idx` = 0, `o_tick` = 0, prescaler = 0, state = DIRECT.
- States: DIRECT, SCAN, and BLANK (BLANK exists only with the macro).
- State is selected by `i_mode` each cycle.
  - Mode change 0→1: the next state is SCAN with idx = 0 and prescaler = 0.
  - Mode change 1→0: the next state is DIRECT.
- DIRECT:
  - `o_idx` <= `i_sel`.
  - `o_y` <= ~(1 << `i_sel`).
  - `o_tick` = 0.
  - The prescaler is held at 0.
- SCAN:
  - The prescaler counts 0..`i_div`.
  - At terminal count, the prescaler clears, `o_tick` pulses, and idx advances.
  - idx wraps to 0 after reaching `i_last`.
  - `o_y` = ~(1 << idx).
- `i_div` = 0: idx advances every cycle and `o_tick` stays high continuously.
- `i_last` = 0: idx stays 0 and `o_tick` still pulses every `i_div`+1 cycles.
- If `i_last` is lowered below the current idx, the next advance goes to 0. Indices above `i_last` are never reached by counting.
- `i_div` and `i_last` are sampled live. A change takes effect from the next prescaler compare.
- `i_en` = 0:
  - `o_y` = all ones and `o_tick` = 0.
  - Prescaler and idx hold.
  - Scanning resumes from the held idx and count when enable returns.
- `i_rst` has priority over all inputs. Reset mid-scan returns to the reset values on the next edge.
- The index increments at SEL_W width with explicit compare to `i_last`; it never relies on natural overflow.

## Timing
- Direct mode: `i_sel` change appears on `o_y` and `o_idx` after exactly one clock.
- Scan step period is `i_div`+1 clocks without the macro.
- `o_tick` is registered, aligned with the edge on which `o_y` shows the new index, and lasts one cycle.
- Enable: `i_en` falling makes `o_y` all ones on the next edge. `i_en` rising restores the strobe on the next edge.
- Mode switch to scan: the first `o_y` shows index 0 one clock after `i_mode` rises, and holds for `i_div`+1 cycles.

## Configuration
- Macro `DECODER_SCAN_BLANK_EN`.
- Defined: each scan advance inserts one BLANK cycle.
  - During BLANK, `o_y` = all ones and `o_tick` = 0.
  - The new index appears the cycle after BLANK, and `o_tick` pulses with it.
  - Step period becomes `i_div`+2 clocks.
  - Direct mode is unaffected.
  - BLANK is anti-ghosting for multiplexed displays.
- Undefined: no BLANK state and no extra cycle. The index switches strobe-to-strobe.

## Structure
- Package `decoder_scan_pkg`:
  - state enum (DIRECT, SCAN, BLANK)
  - function `onehot_n(idx)` returning the active-low one-hot vector
  - constant `ALL_OFF`
- Sub-module `decoder_scan_presc`: DIV_W-bit prescaler with clear, hold, and terminal-count pulse output.
- The top level holds the FSM, the index register and the output registers.

## Test plan
- Reset then direct mode, `i_sel` = 5, SEL_W = 3 → after 1 clock, `o_y` = 8'b1101_1111 and `o_idx` = 5; sweeping 0..7 matches the one-hot table.
- Scan, `i_div` = 3, `i_last` = 7 → `o_idx` 0,1,…,7,0, each held 4 clocks; `o_tick` fires every 4th cycle (5 with the macro, plus one all-ones BLANK cycle).
- Scan, `i_div` = 0, `i_last` = 2 → idx 0,1,2,0 on consecutive cycles; `o_tick` held high.
- While scanning at idx 6, set `i_last` = 3 → the next advance goes to idx 0; 4..7 are never driven afterwards.
- Deassert `i_en` at idx 2 mid-period for 10 clocks → `o_y` = 8'hFF and `o_tick` = 0 during that time; on re-enable, idx 2 resumes with the remaining count.
- Assert `i_rst` mid-scan → next edge gives `o_y` = 8'hFF, `o_idx` = 0, `o_tick` = 0, and the FSM in DIRECT.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared state enum, strobe helper and all-off constant for decoder_scan_n
package decoder_scan_pkg;

  localparam int MAX_OUT_N = 256;

  typedef logic [MAX_OUT_N-1:0] wide_t;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SCAN   = 2'd1,
    BLANK  = 2'd2
  } state_t;

  localparam wide_t ALL_OFF = '1;

  // Callers slice the low 2**SEL_W bits; supports SEL_W up to 8.
  function automatic wide_t onehot_n(input int idx);
    return ~(wide_t'(1) << idx);
  endfunction

endpackage

// File: rtl/decoder_scan_presc.sv
// rtl/decoder_scan_presc.sv - scan-rate prescaler with clear, hold and terminal-count pulse
module decoder_scan_presc
  import decoder_scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tc;

  // >= so a live lowering of i_div below the running count still terminates
  assign tc   = i_run && !i_clr && (cnt_q >= i_div);
  assign o_tc = tc;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_run) begin
      cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered active-low one-of-N decoder with auto-scan; DECODER_SCAN_BLANK_EN adds a blank cycle per step
module decoder_scan_n
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [DIV_W-1:0]      i_div,
  input  logic [SEL_W-1:0]      i_last,
  output logic [(2**SEL_W)-1:0] o_y,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_tick
);

  localparam int                 OUT_N = 2**SEL_W;
  localparam logic [OUT_N-1:0]   Y_OFF = ALL_OFF[OUT_N-1:0];

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [OUT_N-1:0]   y_q, y_d;
  logic               tick_q, tick_d;
  logic               presc_clr, presc_run, presc_tc;

  function automatic logic [OUT_N-1:0] strobe(input logic [SEL_W-1:0] idx);
    wide_t w;
    w = onehot_n(int'(idx));
    return w[OUT_N-1:0];
  endfunction

  decoder_scan_presc #(.DIV_W(DIV_W)) u_presc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (presc_clr),
    .i_run (presc_run),
    .i_div (i_div),
    .o_tc  (presc_tc)
  );

  // >= so lowering i_last below the current index wraps on the next advance
  assign idx_nxt = (idx_q >= i_last) ? '0 : idx_q + SEL_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    tick_d    = 1'b0;
    presc_clr = 1'b0;
    presc_run = 1'b0;
    if (!i_mode) begin
      state_d   = DIRECT;
      presc_clr = 1'b1;
      idx_d     = i_sel;
      y_d       = i_en ? strobe(i_sel) : Y_OFF;
    end else if (state_q == DIRECT) begin
      state_d   = SCAN;
      presc_clr = 1'b1;
      idx_d     = '0;
      y_d       = i_en ? strobe('0) : Y_OFF;
    end else begin
      case (state_q)
        SCAN: begin
          presc_run = i_en;
          if (!i_en) begin
            y_d = Y_OFF;
          end else if (presc_tc) begin
`ifdef DECODER_SCAN_BLANK_EN
            state_d = BLANK;
            y_d     = Y_OFF;
`else
            idx_d   = idx_nxt;
            y_d     = strobe(idx_nxt);
            tick_d  = 1'b1;
`endif
          end else begin
            y_d = strobe(idx_q);
          end
        end
`ifdef DECODER_SCAN_BLANK_EN
        BLANK: begin
          if (!i_en) begin
            y_d = Y_OFF;
          end else begin
            state_d = SCAN;
            idx_d   = idx_nxt;
            y_d     = strobe(idx_nxt);
            tick_d  = 1'b1;
          end
        end
`endif
        default: state_d = DIRECT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= DIRECT;
      idx_q   <= '0;
      y_q     <= Y_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      tick_q  <= tick_d;
    end
  end

  assign o_y    = y_q;
  assign o_idx  = idx_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - directed self-checking bench for decoder_scan_n (either DECODER_SCAN_BLANK_EN build)
module tb_decoder_scan_n;
  import decoder_scan_pkg::*;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLANK_CYC = 1;
`else
  localparam int BLANK_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [2:0]  sel, last;
  logic [15:0] div;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        tick;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(3), .DIV_W(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_mode (mode),
    .i_sel  (sel),
    .i_div  (div),
    .i_last (last),
    .o_y    (y),
    .o_idx  (idx),
    .o_tick (tick)
  );

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] strobe_exp(input int i);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << i);
  endfunction

  task automatic run_scan(input int d, input int l, input int n, input string name);
    int p;
    p = d + 1 + BLANK_CYC;
    mode = 1'b0;
    en   = 1'b1;
    @(negedge clk);
    div  = 16'(d);
    last = 3'(l);
    mode = 1'b1;
    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      int ph, st;
      bit blank;
      ph    = c % p;
      st    = c / p;
      blank = (BLANK_CYC == 1) && (ph == p - 1);
      check({name, "_idx"}, 32'(idx), 32'(st % (l + 1)));
      check({name, "_y"}, 32'(y), blank ? 32'hFF : 32'(strobe_exp(st % (l + 1))));
      check({name, "_tick"}, 32'(tick), 32'(!blank && ph == 0 && c > 0));
      @(negedge clk);
    end
  endtask

  initial begin
    int k, viol;
    vecs[0] = '{1'b1, 3'd0, 8'hFE, 3'd0};
    vecs[1] = '{1'b1, 3'd1, 8'hFD, 3'd1};
    vecs[2] = '{1'b1, 3'd2, 8'hFB, 3'd2};
    vecs[3] = '{1'b1, 3'd3, 8'hF7, 3'd3};
    vecs[4] = '{1'b1, 3'd4, 8'hEF, 3'd4};
    vecs[5] = '{1'b1, 3'd5, 8'hDF, 3'd5};
    vecs[6] = '{1'b1, 3'd6, 8'hBF, 3'd6};
    vecs[7] = '{1'b1, 3'd7, 8'h7F, 3'd7};
    vecs[8] = '{1'b0, 3'd3, 8'hFF, 3'd3};
    vecs[9] = '{1'b1, 3'd3, 8'hF7, 3'd3};

    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd5; div = 16'd0; last = 3'd7;
    repeat (2) @(negedge clk);
    check("rst_y", 32'(y), 32'hFF);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(DIRECT));
    rst = 1'b0;

    @(negedge clk);
    check("direct5_y", 32'(y), 32'hDF);
    check("direct5_idx", 32'(idx), 32'd5);

    for (int i = 0; i < 10; i++) begin
      en  = vecs[i].en;
      sel = vecs[i].sel;
      @(negedge clk);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].idx));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'd0);
    end

    run_scan(3, 7, 40, "scan_d3");
    run_scan(0, 2, 8, "scan_d0");

    // lowering i_last while at idx 6
    run_scan(1, 7, 2, "scan_d1");
    k = 0;
    while (idx != 3'd6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_idx6", 32'(idx), 32'd6);
    last = 3'd3;
    k = 0;
    while (idx == 3'd6 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("lower_wrap", 32'(idx), 32'd0);
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx > 3'd3 || y[7:4] != 4'hF) viol++;
      @(negedge clk);
    end
    check("never_high", 32'(viol), 32'd0);

    // enable drop at idx 2, one clock into its period
    run_scan(3, 7, 1, "scan_en");
    k = 0;
    while (!(idx == 3'd2 && tick) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("reach_idx2", 32'(idx), 32'd2);
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("dis_y", 32'(y), 32'hFF);
      check("dis_tick", 32'(tick), 32'd0);
      check("dis_idx", 32'(idx), 32'd2);
    end
    en = 1'b1;
    @(negedge clk);
    check("reen0_y", 32'(y), 32'hFB);
    check("reen0_idx", 32'(idx), 32'd2);
    @(negedge clk);
    check("reen1_y", 32'(y), 32'hFB);
    check("reen1_tick", 32'(tick), 32'd0);
    @(negedge clk);
`ifdef DECODER_SCAN_BLANK_EN
    check("reen_blank_y", 32'(y), 32'hFF);
    @(negedge clk);
`endif
    check("reen_adv_idx", 32'(idx), 32'd3);
    check("reen_adv_y", 32'(y), 32'hF7);
    check("reen_adv_tick", 32'(tick), 32'd1);

    // reset mid-scan with mode still 1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_y", 32'(y), 32'hFF);
    check("mrst_idx", 32'(idx), 32'd0);
    check("mrst_tick", 32'(tick), 32'd0);
    check("mrst_state", 32'(dut.state_q), 32'(DIRECT));
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
